// File: rtl/sp_ram_1024x32_pkg.sv
// Shared constants and word/address types for the 1024x32 single-port RAM.
package sp_ram_pkg;

  localparam int unsigned SP_RAM_DATA_W = 32;
  localparam int unsigned SP_RAM_ADDR_W = 10;
  localparam int unsigned SP_RAM_DEPTH  = 1024;

  typedef logic [SP_RAM_DATA_W-1:0] sp_ram_word_t;
  typedef logic [SP_RAM_ADDR_W-1:0] sp_ram_addr_t;

endpackage

// File: rtl/sp_ram_1024x32_if.sv
// Access bus of the single-port RAM: write data, shared address, write enable, read data.
interface sp_ram_1024x32_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10
) ();

  logic [DATA_W-1:0] data;
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [DATA_W-1:0] q;

  modport master (output data, output addr, output we, input q);
  modport slave  (input data, input addr, input we, output q);

endinterface

// File: rtl/sp_ram_1024x32_array.sv
// Bare storage array: synchronous write, combinational read. Kept separate so a
// vendor RAM primitive can replace it without touching the top level.
module sp_ram_array #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= data;
    end
  end

  assign rd_data = mem[addr];

endmodule

// File: rtl/sp_ram_1024x32.sv
// 1024x32 single-port RAM with write-first, one-cycle registered read.
// Reset clears only the output register; stored words persist.
module sp_ram_1024x32
  import sp_ram_pkg::*;
#(
  parameter int unsigned DATA_W = SP_RAM_DATA_W,
  parameter int unsigned ADDR_W = SP_RAM_ADDR_W,
  parameter int unsigned DEPTH  = SP_RAM_DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  sp_ram_1024x32_if.slave    bus
);

  if (DEPTH != (2 ** ADDR_W)) begin : g_depth_check
    $error("sp_ram_1024x32: DEPTH must equal 2**ADDR_W");
  end

  logic [DATA_W-1:0] rd_data;
  logic              wr_en;

  // Gating with rst_n keeps clock edges seen during reset from writing.
  assign wr_en = bus.we & rst_n;

  sp_ram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .we      (wr_en),
    .addr    (bus.addr),
    .data    (bus.data),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.q <= '0;
    end else begin
      bus.q <= bus.we ? bus.data : rd_data;
    end
  end

endmodule

// File: tb/tb_sp_ram_1024x32.sv
// Scoreboard bench for sp_ram_1024x32: stimulus queues expected q per cycle,
// a monitor pops and compares one time unit after each rising edge.
module tb_sp_ram_1024x32;
  import sp_ram_pkg::*;

  typedef struct {
    sp_ram_word_t exp;
    string        name;
  } sb_entry_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  sb_entry_t sb [$];
  sp_ram_word_t fill [16];

  sp_ram_1024x32_if #(.DATA_W(32), .ADDR_W(10)) bus ();

  sp_ram_1024x32 #(
    .DATA_W (32),
    .ADDR_W (10),
    .DEPTH  (1024)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input sp_ram_word_t act, input sp_ram_word_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: q=0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One bus cycle: drive on the falling edge, queue the q expected after the next rising edge.
  task automatic cyc(input logic we, input int unsigned a, input sp_ram_word_t d,
                     input sp_ram_word_t exp, input string name);
    sb_entry_t e;
    @(negedge clk);
    bus.we   = we;
    bus.addr = sp_ram_addr_t'(a);
    bus.data = d;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  initial begin : monitor
    sb_entry_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.name, bus.q, e.exp);
      end
    end
  end

  initial begin : stimulus
    int unsigned guard;
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.we   = 1'b0;
    bus.addr = '0;
    bus.data = '0;
    repeat (3) @(posedge clk);
    #1 check("reset_q", bus.q, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    cyc(1'b1, 0, 32'h0000_00FF, 32'h0000_00FF, "wr0");
    cyc(1'b0, 0, 32'h0,         32'h0000_00FF, "rd0");

    for (int unsigned i = 0; i < 16; i++) begin
      fill[i] = sp_ram_word_t'($urandom);
      cyc(1'b1, i, fill[i], fill[i], "fill_wr");
    end
    for (int unsigned i = 0; i < 16; i++) begin
      cyc(1'b0, i, 32'hFFFF_FFFF, fill[i], "fill_rd");
    end

    cyc(1'b1, 5, 32'h1111_1111, 32'h1111_1111, "wf_pre");
    cyc(1'b1, 5, 32'h2222_2222, 32'h2222_2222, "wf_same_edge");
    cyc(1'b0, 5, 32'h0,         32'h2222_2222, "wf_rd");

    cyc(1'b1, 1023, 32'hA5A5_A5A5, 32'hA5A5_A5A5, "hi_wr");
    cyc(1'b1, 0,    32'h5A5A_5A5A, 32'h5A5A_5A5A, "lo_wr");
    cyc(1'b0, 1023, 32'h0,         32'hA5A5_A5A5, "hi_rd");
    cyc(1'b0, 0,    32'h0,         32'h5A5A_5A5A, "lo_rd");

    cyc(1'b1, 7, 32'h1, 32'h1, "ow_wr1");
    cyc(1'b1, 7, 32'h2, 32'h2, "ow_wr2");
    for (int unsigned i = 0; i < 10; i++) begin
      cyc(1'b0, 7, sp_ram_word_t'(i), 32'h2, "hold");
    end

    cyc(1'b1, 9, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "pre_rst_wr");
    cyc(1'b0, 9, 32'h0,         32'hDEAD_BEEF, "pre_rst_rd");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1 check("async_reset", bus.q, 32'h0);
    bus.we   = 1'b1;
    bus.addr = 10'd9;
    bus.data = 32'h0BAD_0BAD;
    repeat (2) @(posedge clk);
    #1 check("reset_hold", bus.q, 32'h0);
    @(negedge clk);
    bus.we = 1'b0;
    rst_n  = 1'b1;
    cyc(1'b0, 9,    32'h0, 32'hDEAD_BEEF, "post_rst_rd9");
    cyc(1'b0, 0,    32'h0, 32'h5A5A_5A5A, "post_rst_rd0");
    cyc(1'b0, 1023, 32'h0, 32'hA5A5_A5A5, "post_rst_rd1023");

    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
